// File: rtl/ball_centroid.sv
// HSV colour-window thresholding with per-frame centroid via shared 32-cycle divider.
// Optional BALL_BBOX_EN adds per-frame bounding-box outputs of matching pixels.
module ball_centroid #(
  parameter int unsigned HUE_LO     = 300,
  parameter int unsigned HUE_HI     = 50,
  parameter int unsigned SAT_MIN    = 16,
  parameter int unsigned VAL_MIN    = 10,
  parameter int unsigned VAL_MAX    = 26,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic        vsync,
  input  logic        line_end,
  input  logic        pix_valid,
  input  logic [8:0]  hue,
  input  logic [4:0]  saturation,
  input  logic [4:0]  value,
  input  logic        hue_invalid,
  output logic [9:0]  ball_x,
  output logic [8:0]  ball_y,
  output logic        ball_found,
  output logic [18:0] pix_count,
  output logic        result_valid,
  output logic        overrun
`ifdef BALL_BBOX_EN
  ,
  output logic [9:0]  bbox_xmin,
  output logic [9:0]  bbox_xmax,
  output logic [8:0]  bbox_ymin,
  output logic [8:0]  bbox_ymax
`endif
);

  localparam logic [8:0]  HUE_LO_C = 9'(HUE_LO);
  localparam logic [8:0]  HUE_HI_C = 9'(HUE_HI);
  localparam logic [4:0]  SAT_MIN_C = 5'(SAT_MIN);
  localparam logic [4:0]  VAL_MIN_C = 5'(VAL_MIN);
  localparam logic [4:0]  VAL_MAX_C = 5'(VAL_MAX);
  localparam logic [18:0] MIN_PIX_C = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIVX, DIVY, DONE} state_t;

  state_t       state_q, state_d;
  logic         vsync_prev_q, vsync_prev_d;
  logic [9:0]   x_cnt_q, x_cnt_d;
  logic [8:0]   y_cnt_q, y_cnt_d;
  logic [18:0]  cnt_q, cnt_d;
  logic [31:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [18:0]  snap_cnt_q, snap_cnt_d;
  logic [31:0]  snap_sum_y_q, snap_sum_y_d;
  logic [31:0]  div_q_q, div_q_d;
  logic [18:0]  div_r_q, div_r_d;
  logic [4:0]   div_cnt_q, div_cnt_d;
  logic [9:0]   quot_x_q, quot_x_d;
  logic [9:0]   ball_x_q, ball_x_d;
  logic [8:0]   ball_y_q, ball_y_d;
  logic         ball_found_q, ball_found_d;
  logic [18:0]  pix_count_q, pix_count_d;
  logic         result_valid_q, result_valid_d;
  logic         overrun_q, overrun_d;
`ifdef BALL_BBOX_EN
  logic [9:0]   xmin_q, xmin_d, xmax_q, xmax_d, snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
  logic [8:0]   ymin_q, ymin_d, ymax_q, ymax_d, snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;
  logic [9:0]   bbox_xmin_q, bbox_xmin_d, bbox_xmax_q, bbox_xmax_d;
  logic [8:0]   bbox_ymin_q, bbox_ymin_d, bbox_ymax_q, bbox_ymax_d;
`endif

  logic        frame_end, hue_ok, pix_match, div_ge, found;
  logic [19:0] r_sh;
  logic [31:0] div_q_next;
  logic [18:0] div_r_next;

  always_comb begin
    frame_end = vsync && !vsync_prev_q;
    if (HUE_LO_C <= HUE_HI_C) hue_ok = (hue >= HUE_LO_C) && (hue <= HUE_HI_C);
    else                      hue_ok = (hue >= HUE_LO_C) || (hue <= HUE_HI_C);
    pix_match = pix_valid && !vsync && !hue_invalid && hue_ok &&
                (saturation >= SAT_MIN_C) && (value >= VAL_MIN_C) && (value <= VAL_MAX_C);

    // One restoring step; a zero divisor never produces a quotient bit.
    r_sh       = {div_r_q, div_q_q[31]};
    div_ge     = (snap_cnt_q != '0) && (r_sh >= {1'b0, snap_cnt_q});
    div_q_next = {div_q_q[30:0], div_ge};
    div_r_next = div_ge ? (r_sh[18:0] - snap_cnt_q) : r_sh[18:0];
    found      = (snap_cnt_q >= MIN_PIX_C) && (snap_cnt_q != '0);

    state_d        = state_q;
    vsync_prev_d   = vsync;
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    cnt_d          = cnt_q;
    sum_x_d        = sum_x_q;
    sum_y_d        = sum_y_q;
    snap_cnt_d     = snap_cnt_q;
    snap_sum_y_d   = snap_sum_y_q;
    div_q_d        = div_q_q;
    div_r_d        = div_r_q;
    div_cnt_d      = div_cnt_q;
    quot_x_d       = quot_x_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    ball_found_d   = ball_found_q;
    pix_count_d    = pix_count_q;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
`ifdef BALL_BBOX_EN
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
    snap_xmin_d = snap_xmin_q; snap_xmax_d = snap_xmax_q;
    snap_ymin_d = snap_ymin_q; snap_ymax_d = snap_ymax_q;
    bbox_xmin_d = bbox_xmin_q; bbox_xmax_d = bbox_xmax_q;
    bbox_ymin_d = bbox_ymin_q; bbox_ymax_d = bbox_ymax_q;
`endif

    if (!vsync) begin
      if (pix_match) begin
        if (cnt_q != '1) cnt_d = cnt_q + 19'd1;
        sum_x_d = sum_x_q + 32'(x_cnt_q);
        sum_y_d = sum_y_q + 32'(y_cnt_q);
`ifdef BALL_BBOX_EN
        if (x_cnt_q < xmin_q) xmin_d = x_cnt_q;
        if (x_cnt_q > xmax_q) xmax_d = x_cnt_q;
        if (y_cnt_q < ymin_q) ymin_d = y_cnt_q;
        if (y_cnt_q > ymax_q) ymax_d = y_cnt_q;
`endif
      end
      if (line_end) begin
        x_cnt_d = '0;
        if (y_cnt_q != '1) y_cnt_d = y_cnt_q + 9'd1;
      end else if (pix_valid && x_cnt_q != '1) begin
        x_cnt_d = x_cnt_q + 10'd1;
      end
    end

    if (frame_end) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      cnt_d   = '0;
      sum_x_d = '0;
      sum_y_d = '0;
`ifdef BALL_BBOX_EN
      xmin_d = '1; xmax_d = '0; ymin_d = '1; ymax_d = '0;
`endif
      if (state_q != IDLE) overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: if (frame_end) begin
        snap_cnt_d   = cnt_q;
        snap_sum_y_d = sum_y_q;
        div_q_d      = sum_x_q;
        div_r_d      = '0;
        div_cnt_d    = '0;
        state_d      = DIVX;
`ifdef BALL_BBOX_EN
        snap_xmin_d = xmin_q; snap_xmax_d = xmax_q;
        snap_ymin_d = ymin_q; snap_ymax_d = ymax_q;
`endif
      end
      DIVX: begin
        div_q_d   = div_q_next;
        div_r_d   = div_r_next;
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) begin
          quot_x_d = div_q_next[9:0];
          div_q_d  = snap_sum_y_q;
          div_r_d  = '0;
          state_d  = DIVY;
        end
      end
      DIVY: begin
        div_q_d   = div_q_next;
        div_r_d   = div_r_next;
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        ball_found_d   = found;
        pix_count_d    = snap_cnt_q;
        result_valid_d = 1'b1;
        state_d        = IDLE;
        if (found) begin
          ball_x_d = quot_x_q;
          ball_y_d = div_q_q[8:0];
`ifdef BALL_BBOX_EN
          bbox_xmin_d = snap_xmin_q; bbox_xmax_d = snap_xmax_q;
          bbox_ymin_d = snap_ymin_q; bbox_ymax_d = snap_ymax_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q        <= IDLE;
      vsync_prev_q   <= 1'b1;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      cnt_q          <= '0;
      sum_x_q        <= '0;
      sum_y_q        <= '0;
      snap_cnt_q     <= '0;
      snap_sum_y_q   <= '0;
      div_q_q        <= '0;
      div_r_q        <= '0;
      div_cnt_q      <= '0;
      quot_x_q       <= '0;
      ball_x_q       <= '0;
      ball_y_q       <= '0;
      ball_found_q   <= 1'b0;
      pix_count_q    <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef BALL_BBOX_EN
      xmin_q <= '1; xmax_q <= '0; ymin_q <= '1; ymax_q <= '0;
      snap_xmin_q <= '0; snap_xmax_q <= '0; snap_ymin_q <= '0; snap_ymax_q <= '0;
      bbox_xmin_q <= '0; bbox_xmax_q <= '0; bbox_ymin_q <= '0; bbox_ymax_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      vsync_prev_q   <= vsync_prev_d;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      cnt_q          <= cnt_d;
      sum_x_q        <= sum_x_d;
      sum_y_q        <= sum_y_d;
      snap_cnt_q     <= snap_cnt_d;
      snap_sum_y_q   <= snap_sum_y_d;
      div_q_q        <= div_q_d;
      div_r_q        <= div_r_d;
      div_cnt_q      <= div_cnt_d;
      quot_x_q       <= quot_x_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      ball_found_q   <= ball_found_d;
      pix_count_q    <= pix_count_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
`ifdef BALL_BBOX_EN
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      snap_xmin_q <= snap_xmin_d; snap_xmax_q <= snap_xmax_d;
      snap_ymin_q <= snap_ymin_d; snap_ymax_q <= snap_ymax_d;
      bbox_xmin_q <= bbox_xmin_d; bbox_xmax_q <= bbox_xmax_d;
      bbox_ymin_q <= bbox_ymin_d; bbox_ymax_q <= bbox_ymax_d;
`endif
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_found   = ball_found_q;
  assign pix_count    = pix_count_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;
`ifdef BALL_BBOX_EN
  assign bbox_xmin = bbox_xmin_q;
  assign bbox_xmax = bbox_xmax_q;
  assign bbox_ymin = bbox_ymin_q;
  assign bbox_ymax = bbox_ymax_q;
`endif

endmodule
